// File: rtl/l1_data_cache_pkg.sv
`default_nettype none
// ============================================================================
// Module      : l1_data_cache_pkg
// Description : Shared types and helpers for the L1 data cache.
// Revision    : 1.0 - initial release
// ============================================================================
package l1_data_cache_pkg;

   localparam int LINE_SIZE        = 128;
   localparam int LINE_WORDS       = LINE_SIZE / 32;
   localparam int L1_SETS_DEFAULT  = 16;
   localparam int OFS_BITS         = $clog2(LINE_WORDS);
   localparam int IDX_BITS_DEFAULT = $clog2(L1_SETS_DEFAULT);
   localparam int TAG_BITS_DEFAULT = 32 - IDX_BITS_DEFAULT - OFS_BITS - 2;

   typedef logic [31:0]          Word;
   typedef logic [LINE_SIZE-1:0] Line;

   typedef enum logic {
      LOAD  = 1'b0,
      STORE = 1'b1
   } MemoryOperation;

   typedef enum logic [2:0] {
      READY     = 3'd0,
      LOOKUP    = 3'd1,
      WRITEBACK = 3'd2,
      FILL_REQ  = 3'd3,
      FILL_WAIT = 3'd4,
      RESPOND   = 3'd5
   } L1State;

   typedef logic [IDX_BITS_DEFAULT-1:0] L1Index;
   typedef logic [TAG_BITS_DEFAULT-1:0] L1Tag;
   typedef logic [OFS_BITS-1:0]         L1WordOffset;

   function automatic L1Index getL1Index(Word addr);
      return L1Index'(addr >> (OFS_BITS + 2));
   endfunction

   function automatic L1Tag getL1Tag(Word addr);
      return L1Tag'(addr >> (OFS_BITS + IDX_BITS_DEFAULT + 2));
   endfunction

   function automatic L1WordOffset getL1WordOffset(Word addr);
      return L1WordOffset'(addr >> 2);
   endfunction

   function automatic Word getWord(Line line, L1WordOffset ofs);
      return line[{ofs, 5'd0} +: 32];
   endfunction

   function automatic Line insertWord(Line line, L1WordOffset ofs, Word w);
      Line r;
      r = line;
      r[{ofs, 5'd0} +: 32] = w;
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/l1_data_cache_line_array.sv
`default_nettype none
// ============================================================================
// Module      : l1_line_array
// Description : Flop-based line storage; valid/dirty async-cleared, tag/data not.
// Revision    : 1.0 - initial release
// ============================================================================
module l1_line_array
   import l1_data_cache_pkg::*;
#(
   parameter int SETS  = 16,
   parameter int IDX_W = $clog2(SETS),
   parameter int TAG_W = 24
) (
   input  logic             clk_in,
   input  logic             rst_n_in,
   input  logic [IDX_W-1:0] rd_index,
   output logic             rd_valid,
   output logic             rd_dirty,
   output logic [TAG_W-1:0] rd_tag,
   output Line              rd_line,
   input  logic             wr_en,
   input  logic [IDX_W-1:0] wr_index,
   input  logic [TAG_W-1:0] wr_tag,
   input  Line              wr_line,
   input  logic             wr_dirty
);

   logic [SETS-1:0]  r_valid;
   logic [SETS-1:0]  r_dirty;
   logic [TAG_W-1:0] r_tag  [SETS];
   Line              r_line [SETS];

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         r_valid <= '0;
         r_dirty <= '0;
      end else if (wr_en) begin
         r_valid[wr_index] <= 1'b1;
         r_dirty[wr_index] <= wr_dirty;
      end
   end

   // Tag and data carry no reset; valid gates every use of them.
   always_ff @(posedge clk_in) begin
      if (wr_en) begin
         r_tag[wr_index]  <= wr_tag;
         r_line[wr_index] <= wr_line;
      end
   end

   assign rd_valid = r_valid[rd_index];
   assign rd_dirty = r_dirty[rd_index];
   assign rd_tag   = r_tag[rd_index];
   assign rd_line  = r_line[rd_index];

endmodule
`default_nettype wire

// File: rtl/l1_data_cache.sv
`default_nettype none
// ============================================================================
// Module      : l1_data_cache
// Description : Direct-mapped write-back/write-allocate L1 data cache.
// Revision    : 1.0 - initial release
// ============================================================================
module l1_data_cache
   import l1_data_cache_pkg::*;
#(
   parameter int L1_SETS        = 16,
   parameter int WORDS_PER_LINE = LINE_SIZE / 32
) (
   input  logic           clk_in,
   input  logic           rst_n_in,
   output logic           cpu_request_ready_out,
   input  logic           cpu_request_valid_in,
   input  Word            cpu_request_address_in,
   input  MemoryOperation cpu_request_operation_in,
   input  Word            cpu_request_data_in,
   input  logic           cpu_response_ready_in,
   output logic           cpu_response_valid_out,
   output Word            cpu_response_data_out,
   input  logic           l2_request_ready_in,
   output logic           l2_request_valid_out,
   output Word            l2_request_address_out,
   output MemoryOperation l2_request_operation_out,
   output Line            l2_request_data_out,
   output logic           l2_response_ready_out,
   input  logic           l2_response_valid_in,
   input  Line            l2_response_data_in
);

   localparam int c_OFS   = $clog2(WORDS_PER_LINE);
   localparam int c_IDX_W = $clog2(L1_SETS);
   localparam int c_TAG_W = 32 - c_IDX_W - c_OFS - 2;

   L1State         r_state, w_state_nxt;
   Word            r_addr, r_wdata;
   MemoryOperation r_op;
   Word            r_resp_data, w_resp_data_nxt;
   Word            r_l2_addr, w_l2_addr_nxt;
   MemoryOperation r_l2_op, w_l2_op_nxt;
   Line            r_l2_data, w_l2_data_nxt;
   logic           w_capture;

   logic [c_IDX_W-1:0] w_index;
   logic [c_TAG_W-1:0] w_tag;
   L1WordOffset        w_ofs;
   Word                w_fill_addr;
   logic               w_hit;

   logic               w_rd_valid, w_rd_dirty;
   logic [c_TAG_W-1:0] w_rd_tag;
   Line                w_rd_line;
   logic               w_wr_en, w_wr_dirty;
   Line                w_wr_line;

   assign w_index     = r_addr[c_OFS+2 +: c_IDX_W];
   assign w_tag       = r_addr[31 -: c_TAG_W];
   assign w_ofs       = getL1WordOffset(r_addr);
   assign w_fill_addr = {w_tag, w_index, {(c_OFS + 2){1'b0}}};
   assign w_hit       = w_rd_valid && (w_rd_tag == w_tag);

   l1_line_array #(
      .SETS  (L1_SETS),
      .IDX_W (c_IDX_W),
      .TAG_W (c_TAG_W)
   ) u_lines (
      .clk_in   (clk_in),
      .rst_n_in (rst_n_in),
      .rd_index (w_index),
      .rd_valid (w_rd_valid),
      .rd_dirty (w_rd_dirty),
      .rd_tag   (w_rd_tag),
      .rd_line  (w_rd_line),
      .wr_en    (w_wr_en),
      .wr_index (w_index),
      .wr_tag   (w_tag),
      .wr_line  (w_wr_line),
      .wr_dirty (w_wr_dirty)
   );

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) r_state <= READY;
      else           r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt            = r_state;
      w_capture              = 1'b0;
      w_resp_data_nxt        = r_resp_data;
      w_l2_addr_nxt          = r_l2_addr;
      w_l2_op_nxt            = r_l2_op;
      w_l2_data_nxt          = r_l2_data;
      w_wr_en                = 1'b0;
      w_wr_dirty             = 1'b0;
      w_wr_line              = l2_response_data_in;
      cpu_request_ready_out  = 1'b0;
      cpu_response_valid_out = 1'b0;
      l2_request_valid_out   = 1'b0;
      l2_response_ready_out  = 1'b0;
      case (r_state)
         READY: begin
            cpu_request_ready_out = 1'b1;
            if (cpu_request_valid_in) begin
               w_capture   = 1'b1;
               w_state_nxt = LOOKUP;
            end
         end
         LOOKUP: begin
            if (w_hit) begin
               if (r_op == LOAD) begin
                  w_resp_data_nxt = getWord(w_rd_line, w_ofs);
                  w_state_nxt     = RESPOND;
               end else begin
                  w_wr_en     = 1'b1;
                  w_wr_dirty  = 1'b1;
                  w_wr_line   = insertWord(w_rd_line, w_ofs, r_wdata);
                  w_state_nxt = READY;
               end
            end else if (w_rd_valid && w_rd_dirty) begin
               // Victim is snapshotted here, before the fill can overwrite the set.
               w_l2_op_nxt   = STORE;
               w_l2_addr_nxt = {w_rd_tag, w_index, {(c_OFS + 2){1'b0}}};
               w_l2_data_nxt = w_rd_line;
               w_state_nxt   = WRITEBACK;
            end else begin
               w_l2_op_nxt   = LOAD;
               w_l2_addr_nxt = w_fill_addr;
               w_state_nxt   = FILL_REQ;
            end
         end
         WRITEBACK: begin
            l2_request_valid_out = 1'b1;
            if (l2_request_ready_in) begin
               w_l2_op_nxt   = LOAD;
               w_l2_addr_nxt = w_fill_addr;
               w_state_nxt   = FILL_REQ;
            end
         end
         FILL_REQ: begin
            l2_request_valid_out = 1'b1;
            if (l2_request_ready_in) w_state_nxt = FILL_WAIT;
         end
         FILL_WAIT: begin
            l2_response_ready_out = 1'b1;
            if (l2_response_valid_in) begin
               w_wr_en = 1'b1;
               if (r_op == LOAD) begin
                  w_resp_data_nxt = getWord(l2_response_data_in, w_ofs);
                  w_state_nxt     = RESPOND;
               end else begin
                  w_wr_line   = insertWord(l2_response_data_in, w_ofs, r_wdata);
                  w_wr_dirty  = 1'b1;
                  w_state_nxt = READY;
               end
            end
         end
         RESPOND: begin
            cpu_response_valid_out = 1'b1;
            if (cpu_response_ready_in) w_state_nxt = READY;
         end
         default: w_state_nxt = READY;
      endcase
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         r_addr      <= '0;
         r_op        <= LOAD;
         r_wdata     <= '0;
         r_resp_data <= '0;
         r_l2_addr   <= '0;
         r_l2_op     <= LOAD;
         r_l2_data   <= '0;
      end else begin
         if (w_capture) begin
            r_addr  <= cpu_request_address_in;
            r_op    <= cpu_request_operation_in;
            r_wdata <= cpu_request_data_in;
         end
         r_resp_data <= w_resp_data_nxt;
         r_l2_addr   <= w_l2_addr_nxt;
         r_l2_op     <= w_l2_op_nxt;
         r_l2_data   <= w_l2_data_nxt;
      end
   end

   assign cpu_response_data_out    = r_resp_data;
   assign l2_request_address_out   = r_l2_addr;
   assign l2_request_operation_out = r_l2_op;
   assign l2_request_data_out      = r_l2_data;

endmodule
`default_nettype wire

// File: tb/tb_l1_data_cache.sv
`default_nettype none
// ============================================================================
// Module      : tb_l1_data_cache
// Description : Directed + random bench; flat-memory reference with L2 model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_l1_data_cache;
   import l1_data_cache_pkg::*;

   logic           clk_in = 1'b0;
   logic           rst_n_in;
   logic           cpu_request_ready_out;
   logic           cpu_request_valid_in;
   Word            cpu_request_address_in;
   MemoryOperation cpu_request_operation_in;
   Word            cpu_request_data_in;
   logic           cpu_response_ready_in;
   logic           cpu_response_valid_out;
   Word            cpu_response_data_out;
   logic           l2_request_ready_in;
   logic           l2_request_valid_out;
   Word            l2_request_address_out;
   MemoryOperation l2_request_operation_out;
   Line            l2_request_data_out;
   logic           l2_response_ready_out;
   logic           l2_response_valid_in;
   Line            l2_response_data_in;

   always #5 clk_in = ~clk_in;

   l1_data_cache #(.L1_SETS(16)) dut (
      .clk_in                   (clk_in),
      .rst_n_in                 (rst_n_in),
      .cpu_request_ready_out    (cpu_request_ready_out),
      .cpu_request_valid_in     (cpu_request_valid_in),
      .cpu_request_address_in   (cpu_request_address_in),
      .cpu_request_operation_in (cpu_request_operation_in),
      .cpu_request_data_in      (cpu_request_data_in),
      .cpu_response_ready_in    (cpu_response_ready_in),
      .cpu_response_valid_out   (cpu_response_valid_out),
      .cpu_response_data_out    (cpu_response_data_out),
      .l2_request_ready_in      (l2_request_ready_in),
      .l2_request_valid_out     (l2_request_valid_out),
      .l2_request_address_out   (l2_request_address_out),
      .l2_request_operation_out (l2_request_operation_out),
      .l2_request_data_out      (l2_request_data_out),
      .l2_response_ready_out    (l2_response_ready_out),
      .l2_response_valid_in     (l2_response_valid_in),
      .l2_response_data_in      (l2_response_data_in)
   );

   int tests = 0;
   int fails = 0;
   int wb_count = 0;

   // l2mem holds what L2 has; flat holds what a program should observe.
   Word l2mem [Word];
   Word flat  [Word];
   bit          mv [16];
   bit          md [16];
   logic [23:0] mt [16];

   function automatic Word init_word(Word a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   function automatic Word rd_l2(Word a);
      return l2mem.exists(a) ? l2mem[a] : init_word(a);
   endfunction

   function automatic Word rd_flat(Word a);
      return flat.exists(a) ? flat[a] : init_word(a);
   endfunction

   function automatic Line flat_line(Word base);
      Line l;
      for (int w = 0; w < 4; w++) l[w*32 +: 32] = rd_flat(base + 32'(w * 4));
      return l;
   endfunction

   function automatic Line l2_line(Word base);
      Line l;
      for (int w = 0; w < 4; w++) l[w*32 +: 32] = rd_l2(base + 32'(w * 4));
      return l;
   endfunction

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      flat = l2mem;
      for (int i = 0; i < 16; i++) begin
         mv[i] = 1'b0;
         md[i] = 1'b0;
      end
   endtask

   task automatic drive_idle();
      cpu_request_valid_in     = 1'b0;
      cpu_request_address_in   = '0;
      cpu_request_operation_in = LOAD;
      cpu_request_data_in      = '0;
      cpu_response_ready_in    = 1'b0;
      l2_request_ready_in      = 1'b0;
      l2_response_valid_in     = 1'b0;
      l2_response_data_in      = '0;
   endtask

   task automatic do_reset();
      drive_idle();
      rst_n_in = 1'b0;
      repeat (2) @(negedge clk_in);
      rst_n_in = 1'b1;
      model_reset();
      @(negedge clk_in);
      check("ready_after_reset", cpu_request_ready_out, 1'b1);
   endtask

   // One CPU request, acting as L2 too; abort pulls reset once FILL_WAIT is reached.
   task automatic run_req(input MemoryOperation op, input Word addr, input Word data,
                          input int l2_delay, input int rsp_delay, input bit abort);
      int idx, cyc, l2_wait, rsp_wait, rsp_first, done_cyc;
      logic [23:0] tag;
      Word line_addr, wb_addr, exp_rsp;
      Line wb_line, captured;
      bit hit, exp_wb, wb_seen, fill_req_seen, fill_done, rsp_seen, done;
      bit l2_hs, rsp_hs, fill_drive;
      idx       = int'(addr[7:4]);
      tag       = addr[31:8];
      line_addr = {addr[31:4], 4'b0};
      hit       = mv[idx] && (mt[idx] == tag);
      exp_wb    = !hit && mv[idx] && md[idx];
      wb_addr   = {mt[idx], addr[7:4], 4'b0};
      wb_line   = flat_line(wb_addr);
      exp_rsp   = rd_flat({addr[31:2], 2'b00});
      captured  = '0;
      {cyc, l2_wait, rsp_wait, rsp_first, done_cyc} = '0;
      {wb_seen, fill_req_seen, fill_done, rsp_seen, done, l2_hs, rsp_hs, fill_drive} = '0;

      @(negedge clk_in);
      check("req_ready", cpu_request_ready_out, 1'b1);
      cpu_request_valid_in     = 1'b1;
      cpu_request_address_in   = addr;
      cpu_request_operation_in = op;
      cpu_request_data_in      = data;
      @(posedge clk_in);
      #1;
      cpu_request_valid_in = 1'b0;

      while (!done && cyc < 100) begin
         @(negedge clk_in);
         cyc++;
         if (fill_drive) begin
            l2_response_valid_in = 1'b0;
            fill_drive = 1'b0;
            fill_done  = 1'b1;
         end
         if (rsp_hs) begin
            cpu_response_ready_in = 1'b0;
            rsp_hs = 1'b0;
         end
         if (l2_hs) begin
            l2_request_ready_in = 1'b0;
            l2_hs   = 1'b0;
            l2_wait = 0;
            if (exp_wb && !wb_seen) begin
               wb_seen = 1'b1;
               wb_count++;
               for (int w = 0; w < 4; w++) l2mem[wb_addr + 32'(w * 4)] = captured[w*32 +: 32];
            end else begin
               fill_req_seen = 1'b1;
               if (abort) begin
                  #2 rst_n_in = 1'b0;
                  #1;
                  check("abort_l2_req_valid", l2_request_valid_out, 1'b0);
                  check("abort_l2_rsp_ready", l2_response_ready_out, 1'b0);
                  check("abort_cpu_rsp_valid", cpu_response_valid_out, 1'b0);
                  check("abort_l2_addr", l2_request_address_out, 32'h0);
                  drive_idle();
                  done = 1'b1;
               end else begin
                  check("fill_ready", l2_response_ready_out, 1'b1);
                  l2_response_valid_in = 1'b1;
                  l2_response_data_in  = l2_line(line_addr);
                  fill_drive = 1'b1;
               end
            end
         end
         if (!done) begin
            if (l2_request_valid_out === 1'b1) begin
               if (exp_wb && !wb_seen) begin
                  check("wb_op", l2_request_operation_out, STORE);
                  check("wb_addr", l2_request_address_out, wb_addr);
                  check("wb_data", l2_request_data_out, wb_line);
                  captured = l2_request_data_out;
               end else if (!hit && !fill_req_seen) begin
                  check("fill_op", l2_request_operation_out, LOAD);
                  check("fill_addr", l2_request_address_out, line_addr);
               end else begin
                  check("l2_unexpected", l2_request_valid_out, 1'b0);
               end
               if (l2_wait < l2_delay) l2_wait++;
               else begin
                  l2_request_ready_in = 1'b1;
                  l2_hs = 1'b1;
               end
            end
            if (cpu_response_valid_out === 1'b1) begin
               if (rsp_first == 0) rsp_first = cyc;
               if (op == LOAD) check("rsp_data", cpu_response_data_out, exp_rsp);
               else            check("store_rsp", cpu_response_valid_out, 1'b0);
               if (rsp_wait < rsp_delay) rsp_wait++;
               else begin
                  cpu_response_ready_in = 1'b1;
                  rsp_hs   = 1'b1;
                  rsp_seen = 1'b1;
               end
            end
            if (cpu_request_ready_out === 1'b1) begin
               done     = 1'b1;
               done_cyc = cyc;
            end
         end
      end

      check("timeout", done, 1'b1);
      if (!abort) begin
         check("wb_seen", wb_seen, exp_wb);
         check("fill_seen", fill_done, !hit);
         check("rsp_seen", rsp_seen, op == LOAD);
         if (hit && op == LOAD) begin
            check("hit_rsp_latency", rsp_first, 2);
            if (rsp_delay == 0) check("hit_next_ready", done_cyc, 3);
         end else if (hit) begin
            check("store_hit_ready", done_cyc, 2);
         end
         if (op == STORE) flat[{addr[31:2], 2'b00}] = data;
         md[idx] = hit ? (md[idx] | (op == STORE)) : (op == STORE);
         mv[idx] = 1'b1;
         mt[idx] = tag;
      end
   endtask

   initial begin
      int wb0;
      drive_idle();
      rst_n_in = 1'b0;
      l2mem[32'h100] = 32'hA;
      l2mem[32'h104] = 32'hB;
      l2mem[32'h108] = 32'hC;
      l2mem[32'h10C] = 32'hD;
      #12;
      check("rst_cpu_rsp_valid", cpu_response_valid_out, 1'b0);
      check("rst_l2_req_valid", l2_request_valid_out, 1'b0);
      check("rst_l2_rsp_ready", l2_response_ready_out, 1'b0);
      check("rst_cpu_rsp_data", cpu_response_data_out, 32'h0);
      check("rst_l2_addr", l2_request_address_out, 32'h0);
      check("rst_l2_data", l2_request_data_out, 128'h0);
      check("rst_l2_op", l2_request_operation_out, LOAD);
      @(negedge clk_in);
      rst_n_in = 1'b1;
      model_reset();
      @(negedge clk_in);
      check("ready_after_reset", cpu_request_ready_out, 1'b1);

      // Cold miss then hit on the same line.
      run_req(LOAD, 32'h104, 32'h0, 0, 0, 1'b0);
      run_req(LOAD, 32'h104, 32'h0, 0, 0, 1'b0);

      // Async reset while waiting for fill data; line must miss again afterwards.
      run_req(LOAD, 32'h284, 32'h0, 1, 0, 1'b1);
      @(negedge clk_in);
      rst_n_in = 1'b1;
      model_reset();
      run_req(LOAD, 32'h104, 32'h0, 0, 0, 1'b0);

      // Store miss, hit load, then dirty eviction under back-pressure.
      do_reset();
      run_req(STORE, 32'h108, 32'h55, 0, 0, 1'b0);
      run_req(LOAD, 32'h108, 32'h0, 0, 0, 1'b0);
      run_req(LOAD, 32'h204, 32'h0, 5, 3, 1'b0);

      // Fill every set, dirty each, then evict all with conflicting tags.
      do_reset();
      wb0 = wb_count;
      for (int s = 0; s < 16; s++) run_req(LOAD, 32'h1000 + 32'(s * 16), 32'h0, 0, 0, 1'b0);
      for (int s = 0; s < 16; s++) run_req(STORE, 32'h1004 + 32'(s * 16), $urandom, 0, 0, 1'b0);
      for (int s = 0; s < 16; s++) run_req(LOAD, 32'h2008 + 32'(s * 16), 32'h0, 0, 0, 1'b0);
      check("writeback_count", wb_count - wb0, 16);

      // Random traffic over a small address pool to force hits, conflicts and evictions.
      for (int n = 0; n < 300; n++) begin
         Word a;
         MemoryOperation o;
         a = {22'h0, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
              2'($urandom_range(0, 3)), 2'b00};
         o = ($urandom_range(0, 1) == 1) ? STORE : LOAD;
         run_req(o, a, $urandom, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), 1'b0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
